// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver
// Description : 4-digit common-anode seven-segment scan driver with hex
//               decode, per-digit enable/decimal point and optional
//               leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_driver #(
  parameter bit BLANK_LEADING_ZEROS = 1'b0
) (
  input  logic        slow_clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [1:0]  anode_driver,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [1:0] r_digit;
  logic [3:0] w_nibble;
  logic [3:0] w_blank;
  logic       w_sel_blank;
  logic [6:0] w_hex;

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_digit <= 2'd0;
    end else begin
      r_digit <= r_digit + 2'd1;
    end
  end

  assign anode_driver = r_digit;

  // Digit 0 always shows something; higher digits may vanish when they and
  // every digit above them are zero.
  generate
    for (genvar k = 0; k < 4; k++) begin : g_blank
      if (k == 0) begin : g_d0
        assign w_blank[k] = ~digit_en[k];
      end else begin : g_dk
        assign w_blank[k] = ~digit_en[k] |
                            (BLANK_LEADING_ZEROS & (value[15:4*k] == '0));
      end
    end
  endgenerate

  always_comb begin
    w_nibble = value[3:0];
    case (r_digit)
      2'd0: w_nibble = value[3:0];
      2'd1: w_nibble = value[7:4];
      2'd2: w_nibble = value[11:8];
      2'd3: w_nibble = value[15:12];
      default: w_nibble = value[3:0];
    endcase
  end

  assign w_sel_blank = w_blank[r_digit];

  always_comb begin
    w_hex = 7'h7F;
    case (w_nibble)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  always_comb begin
    an = 4'b1111;
    if (!w_sel_blank) begin
      an[r_digit] = 1'b0;
    end
    seg = w_sel_blank ? 7'h7F : w_hex;
    dp  = w_sel_blank ? 1'b1 : ~dp_in[r_digit];
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_driver
// Description : Scoreboard bench for display_scan_driver, both blanking modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [1:0]  idx0, idx1;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  display_scan_driver #(.BLANK_LEADING_ZEROS(1'b0)) u_dut0 (
    .slow_clock(clk), .reset(rst), .value(value), .digit_en(digit_en),
    .dp_in(dp_in), .anode_driver(idx0), .an(an0), .seg(seg0), .dp(dp0));

  display_scan_driver #(.BLANK_LEADING_ZEROS(1'b1)) u_dut1 (
    .slow_clock(clk), .reset(rst), .value(value), .digit_en(digit_en),
    .dp_in(dp_in), .anode_driver(idx1), .an(an1), .seg(seg1), .dp(dp1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] an   [2];
    logic [6:0] seg  [2];
    logic       dp   [2];
  } exp_t;

  exp_t exp_q[$];
  event ev_present;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_idx = 0;
  bit   m_valid = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference: what a human would read off the display for digit k.
  function automatic void model(input int blz, input int k, input int v,
                                input logic [3:0] en, input logic [3:0] dpi,
                                output logic [3:0] a, output logic [6:0] s,
                                output logic d);
    bit blank;
    blank = (en[k] == 1'b0) || (blz == 1 && k > 0 && (v >> (4 * k)) == 0);
    if (blank) begin
      a = 4'hF; s = 7'h7F; d = 1'b1;
    end else begin
      a = 4'hF ^ 4'(1 << k);
      s = hex_tab[(v >> (4 * k)) % 16];
      d = !dpi[k];
    end
  endfunction

  task automatic push_expect();
    exp_t e;
    e.idx = m_idx;
    for (int b = 0; b < 2; b++) begin
      model(b, m_idx, int'(value), digit_en, dp_in, e.an[b], e.seg[b], e.dp[b]);
    end
    exp_q.push_back(e);
    ->ev_present;
  endtask

  // One scan cycle: advance the reference index across the edge, then apply
  // the next inputs; optionally change value mid-cycle.
  task automatic cyc(input logic r, input logic [15:0] v, input logic [3:0] e,
                     input logic [3:0] d, input bit mid);
    @(posedge clk);
    if (rst) begin
      m_idx = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_idx = (m_idx + 1) % 4;
    end
    #1;
    rst = r; value = v; digit_en = e; dp_in = d;
    if (m_valid) push_expect();
    if (mid) begin
      #2;
      value = 16'($urandom);
      if (m_valid) push_expect();
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [1:0] ai [2];
    logic [3:0] aa [2];
    logic [6:0] as [2];
    logic       ad [2];
    forever begin
      @(ev_present);
      #1;
      ai = '{idx0, idx1}; aa = '{an0, an1}; as = '{seg0, seg1}; ad = '{dp0, dp1};
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty actual=output presented required=queued expectation");
      end else begin
        e = exp_q.pop_front();
        for (int b = 0; b < 2; b++) begin
          n_vec++;
          if (ai[b] !== 2'(e.idx) || aa[b] !== e.an[b] ||
              as[b] !== e.seg[b] || ad[b] !== e.dp[b]) begin
            n_err++;
            $display("FAIL scan_blz%0d t=%0t actual idx=%0d an=%h seg=%h dp=%b required idx=%0d an=%h seg=%h dp=%b",
                     b, $time, ai[b], aa[b], as[b], ad[b], e.idx, e.an[b], e.seg[b], e.dp[b]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst = 1'b1; value = 16'h0; digit_en = 4'hF; dp_in = 4'h0;
    cyc(1'b1, 16'h12AF, 4'hF, 4'h0, 1'b0);
    cyc(1'b0, 16'h12AF, 4'hF, 4'h0, 1'b0);
    repeat (6) cyc(1'b0, 16'h12AF, 4'hF, 4'h0, 1'b0);
    guard = 0;
    while (m_idx != 2 && guard < 8) begin
      cyc(1'b0, 16'h12AF, 4'hF, 4'h0, 1'b0);
      guard++;
    end
    cyc(1'b1, 16'h12AF, 4'hF, 4'h0, 1'b0);
    cyc(1'b0, 16'h12AF, 4'hF, 4'h0, 1'b0);
    repeat (3) cyc(1'b0, 16'h12AF, 4'hF, 4'h0, 1'b0);
    repeat (4) cyc(1'b0, 16'h8888, 4'b1011, 4'h0, 1'b0);
    repeat (4) cyc(1'b0, 16'h0005, 4'hF, 4'h0, 1'b0);
    repeat (4) cyc(1'b0, 16'h0000, 4'hF, 4'h0, 1'b0);
    repeat (4) cyc(1'b0, 16'h0A30, 4'hF, 4'b0100, 1'b0);
    repeat (4) cyc(1'b0, 16'h0400, 4'hF, 4'b0100, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h000F;
        1: v = v & 16'h00FF;
        2: v = v & 16'h0FFF;
        default: ;
      endcase
      cyc(($urandom_range(0, 19) == 0), v,
          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
          4'($urandom), ($urandom_range(0, 3) == 0));
    end
    #20;
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
